// File: rtl/out_uart_tx.sv
// out_uart_tx: watches the TD4 output port, queues each change in a small FIFO
// and sends every queued nibble as an ASCII hex character on an 8N1 UART line.
// Build option: define OUT_UART_PARITY_EN to insert an even-parity bit (8E1).
module out_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] OUT_DATA,
    output logic       TXD,
    output logic       BUSY,
    output logic       OVERFLOW
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state_q;
    logic [BAUD_W-1:0]  baud_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         data_q;
    logic               txd_q;

    logic [3:0]         prev_q;
    logic [3:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q;

    logic               baud_end;
    logic               pop;
    logic               push_req;
    logic               push_ok;
    logic [3:0]         head;
    logic [7:0]         head_enc;

    assign baud_end = (baud_q == BAUD_LAST);
    // A pop happens when the line is free: idle, or the last cycle of a stop bit.
    assign pop      = (count_q != '0) &&
                      ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_end));
    assign push_req = (OUT_DATA != prev_q);
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok  = push_req && ((count_q != CNT_FULL) || pop);
    assign head     = mem_q[rd_ptr_q];
    assign head_enc = (head <= 4'd9) ? (8'h30 + {4'h0, head}) : (8'h37 + {4'h0, head});

    // Next-state arithmetic for the FIFO pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= OUT_DATA;
        end
    end

    // Change detector, FIFO bookkeeping and sticky overflow flag.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            prev_q     <= 4'h0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_q   <= OUT_DATA;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_req && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Transmit FSM with registered serial output; baud counter restarts on each state entry.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            data_q    <= 8'h00;
            txd_q     <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    txd_q  <= 1'b1;
                    baud_q <= '0;
                    if (pop) begin
                        data_q  <= head_enc;
                        txd_q   <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        baud_q    <= '0;
                        bit_idx_q <= 3'd0;
                        txd_q     <= data_q[0];
                        state_q   <= S_DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
                            txd_q   <= ^data_q;
                            state_q <= S_PARITY;
`else
                            txd_q   <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= data_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                S_PARITY: begin
`ifdef OUT_UART_PARITY_EN
                    if (baud_end) begin
                        baud_q  <= '0;
                        txd_q   <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
`else
                    txd_q   <= 1'b1;
                    baud_q  <= '0;
                    state_q <= S_IDLE;
`endif
                end
                S_STOP: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (pop) begin
                            data_q  <= head_enc;
                            txd_q   <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    baud_q  <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign TXD      = txd_q;
    assign BUSY     = (state_q != S_IDLE) || (count_q != '0);
    assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: a queue/timer reference model predicts TXD, BUSY and
// OVERFLOW every cycle; a line receiver decodes frames for spec-value checks.
module tb_out_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef OUT_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic [3:0] OUT_DATA = 4'h0;
    logic       TXD;
    logic       BUSY;
    logic       OVERFLOW;

    int checks = 0;
    int failures = 0;

    out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .CLR(CLR), .OUT_DATA(OUT_DATA),
        .TXD(TXD), .BUSY(BUSY), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    // Reference model: pending nibbles plus cycles left in the current frame.
    logic [3:0] m_prev;
    logic [3:0] m_q[$];
    int         m_rem;
    logic [7:0] m_byte;
    logic       m_ovf;
    logic [7:0] exp_bytes[$];

    // Line receiver state.
    int         cyc = 0;
    bit         rx_active = 0;
    int         rx_pos = 0;
    logic [10:0] rx_bits;
    logic [7:0] rx_q[$];
    logic       rx_par_q[$];
    int         rx_start_q[$];

    function automatic logic [7:0] ascii_hex(input logic [3:0] n);
        int v;
        v = n;
        if (v < 10) return 8'(48 + v);     // '0'..'9'
        return 8'(65 + v - 10);            // 'A'..'F'
    endfunction

    function automatic logic m_txd();
        int p, b;
        if (m_rem == 0) return 1'b1;
        p = FRAME - m_rem;
        b = p / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
        if (NB == 11 && b == 9) return ^m_byte;
        return 1'b1;
    endfunction

    function automatic logic m_busy();
        return (m_rem > 0) || (m_q.size() > 0);
    endfunction

    task automatic model_reset();
        m_prev = 4'h0;
        m_q.delete();
        m_rem = 0;
        m_byte = 8'h00;
        m_ovf = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] nib;
        bit pop, push, accept;
        if (!CLR) begin
            model_reset();
            return;
        end
        pop    = (m_rem <= 1) && (m_q.size() > 0);
        push   = (OUT_DATA != m_prev);
        accept = push && ((m_q.size() < DEPTH) || pop);
        if (pop) begin
            nib = m_q.pop_front();
            m_byte = ascii_hex(nib);
            m_rem = FRAME;
            exp_bytes.push_back(m_byte);
        end else if (m_rem > 0) begin
            m_rem--;
        end
        if (accept) m_q.push_back(OUT_DATA);
        if (push && !accept) m_ovf = 1'b1;
        m_prev = OUT_DATA;
    endtask

    task automatic rx_sample();
        if (!CLR) begin
            rx_active = 0;
            return;
        end
        if (!rx_active) begin
            if (TXD === 1'b0) begin
                rx_active = 1;
                rx_pos = 0;
                rx_bits = '0;
                rx_start_q.push_back(cyc);
            end
        end else begin
            rx_pos++;
        end
        if (rx_active) begin
            if (rx_pos % CPB == CPB / 2) rx_bits[rx_pos / CPB] = TXD;
            if (rx_pos == FRAME - 1) begin
                rx_q.push_back(rx_bits[8:1]);
                rx_par_q.push_back(rx_bits[9]);
                $display("frame at cyc %0d: byte=0x%02h char=%c par/stop=%b stop=%b",
                         cyc, rx_bits[8:1], rx_bits[8:1], rx_bits[9], rx_bits[NB-1]);
                rx_active = 0;
            end
        end
    endtask

    // One clock: model follows the active edge, receiver samples at the falling edge.
    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        cyc++;
        rx_sample();
    endtask

    task automatic clear_logs();
        rx_q.delete();
        rx_par_q.delete();
        rx_start_q.delete();
        exp_bytes.delete();
    endtask

    task automatic apply_reset();
        CLR = 1'b0;
        OUT_DATA = 4'h0;
        model_reset();
        tick();
        tick();
        CLR = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        CLR = 1'b0;
        OUT_DATA = 4'h0;
        model_reset();
        tick();
        checks++;
        if ({TXD, BUSY, OVERFLOW} !== 3'b100) begin
            failures++;
            $display("FAIL reset_state txd/busy/ovf=%b%b%b required 100", TXD, BUSY, OVERFLOW);
        end
        CLR = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({TXD, BUSY, OVERFLOW} !== 3'b100) begin
                failures++;
                $display("FAIL reset_const_zero cyc=%0d txd/busy/ovf=%b%b%b required 100", cyc, TXD, BUSY, OVERFLOW);
            end
        end
        clear_logs();
    endtask

    task automatic test_single();
        int i1, i2;
        logic [7:0] got;
        apply_reset();
        OUT_DATA = 4'h5;
        i1 = -1;
        i2 = -1;
        for (int c = 0; c < FRAME + 20; c++) begin
            tick();
            checks++;
            if (TXD !== m_txd() || BUSY !== m_busy() || OVERFLOW !== m_ovf) begin
                failures++;
                $display("FAIL single_cycle cyc=%0d txd/busy/ovf=%b%b%b required %b%b%b",
                         cyc, TXD, BUSY, OVERFLOW, m_txd(), m_busy(), m_ovf);
            end
            if (i1 < 0 && TXD === 1'b0) i1 = c;
            if (i1 >= 0 && i2 < 0 && BUSY === 1'b0) i2 = c;
        end
        checks++;
        if (i1 != 1) begin
            failures++;
            $display("FAIL txd_fall_latency got sample %0d required 1", i1);
        end
        checks++;
        if (i2 - i1 != FRAME) begin
            failures++;
            $display("FAIL busy_duration got %0d required %0d", i2 - i1, FRAME);
        end
        got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        checks++;
        if (rx_q.size() != 1 || got !== 8'h35) begin
            failures++;
            $display("FAIL single_byte frames=%0d byte=0x%02h required 1 frame 0x35", rx_q.size(), got);
        end
        checks++;
        if (OVERFLOW !== 1'b0) begin
            failures++;
            $display("FAIL single_overflow got %b required 0", OVERFLOW);
        end
    endtask

    task automatic test_hold();
        logic [7:0] got;
        apply_reset();
        OUT_DATA = 4'hA;
        for (int c = 0; c < FRAME + 100; c++) begin
            tick();
            checks++;
            if (TXD !== m_txd() || BUSY !== m_busy() || OVERFLOW !== m_ovf) begin
                failures++;
                $display("FAIL hold_cycle cyc=%0d txd/busy/ovf=%b%b%b required %b%b%b",
                         cyc, TXD, BUSY, OVERFLOW, m_txd(), m_busy(), m_ovf);
            end
        end
        got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        checks++;
        if (rx_q.size() != 1 || got !== 8'h41) begin
            failures++;
            $display("FAIL hold_frames frames=%0d byte=0x%02h required 1 frame 0x41", rx_q.size(), got);
        end
    endtask

    task automatic test_back_to_back_overflow();
        logic [7:0] want;
        apply_reset();
        for (int v = 1; v <= 6; v++) begin
            OUT_DATA = 4'(v);
            tick();
            checks++;
            if (TXD !== m_txd() || BUSY !== m_busy() || OVERFLOW !== m_ovf) begin
                failures++;
                $display("FAIL burst_cycle cyc=%0d txd/busy/ovf=%b%b%b required %b%b%b",
                         cyc, TXD, BUSY, OVERFLOW, m_txd(), m_busy(), m_ovf);
            end
        end
        for (int c = 0; c < 5 * FRAME + 30; c++) begin
            tick();
            checks++;
            if (TXD !== m_txd() || BUSY !== m_busy() || OVERFLOW !== m_ovf) begin
                failures++;
                $display("FAIL drain_cycle cyc=%0d txd/busy/ovf=%b%b%b required %b%b%b",
                         cyc, TXD, BUSY, OVERFLOW, m_txd(), m_busy(), m_ovf);
            end
        end
        checks++;
        if (rx_q.size() != 5) begin
            failures++;
            $display("FAIL burst_frame_count got %0d required 5", rx_q.size());
        end
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            want = 8'h31 + 8'(i);
            checks++;
            if (rx_q[i] !== want) begin
                failures++;
                $display("FAIL burst_byte[%0d] got 0x%02h required 0x%02h", i, rx_q[i], want);
            end
        end
        for (int i = 0; i + 1 < rx_start_q.size(); i++) begin
            checks++;
            if (rx_start_q[i+1] - rx_start_q[i] != FRAME) begin
                failures++;
                $display("FAIL burst_gap[%0d] got %0d cycles required %0d", i,
                         rx_start_q[i+1] - rx_start_q[i], FRAME);
            end
        end
        checks++;
        if (OVERFLOW !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky got %b required 1", OVERFLOW);
        end
    endtask

    task automatic test_clr_mid_frame();
        logic [3:0] v;
        logic [7:0] got;
        v = 4'($urandom_range(1, 15));
        if (v == OUT_DATA) v = v ^ 4'h8;
        if (v == 4'h0) v = 4'h9;
        OUT_DATA = v;
        for (int c = 0; c < 2 + 3 * CPB; c++) begin
            tick();
            checks++;
            if (TXD !== m_txd() || BUSY !== m_busy() || OVERFLOW !== m_ovf) begin
                failures++;
                $display("FAIL pre_clr_cycle cyc=%0d txd/busy/ovf=%b%b%b required %b%b%b",
                         cyc, TXD, BUSY, OVERFLOW, m_txd(), m_busy(), m_ovf);
            end
        end
        #2;
        CLR = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({TXD, BUSY, OVERFLOW} !== 3'b100) begin
            failures++;
            $display("FAIL clr_async txd/busy/ovf=%b%b%b required 100", TXD, BUSY, OVERFLOW);
        end
        tick();
        tick();
        CLR = 1'b1;
        clear_logs();
        for (int c = 0; c < 2 * FRAME + 10; c++) begin
            tick();
            checks++;
            if (TXD !== m_txd() || BUSY !== m_busy() || OVERFLOW !== m_ovf) begin
                failures++;
                $display("FAIL post_clr_cycle cyc=%0d txd/busy/ovf=%b%b%b required %b%b%b",
                         cyc, TXD, BUSY, OVERFLOW, m_txd(), m_busy(), m_ovf);
            end
        end
        got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        checks++;
        if (rx_q.size() != 1 || got !== ascii_hex(v)) begin
            failures++;
            $display("FAIL post_clr_frame frames=%0d byte=0x%02h required 1 frame 0x%02h",
                     rx_q.size(), got, ascii_hex(v));
        end
    endtask

    task automatic test_wrap();
        logic [7:0] want[$];
        logic [3:0] v;
        apply_reset();
        for (int n = 0; n < 10; n++) begin
            v = 4'($urandom_range(0, 15));
            if (v == OUT_DATA) v = v + 4'd1;
            OUT_DATA = v;
            want.push_back(ascii_hex(v));
            for (int c = 0; c < FRAME + 5; c++) begin
                tick();
                checks++;
                if (TXD !== m_txd() || BUSY !== m_busy() || OVERFLOW !== m_ovf) begin
                    failures++;
                    $display("FAIL wrap_cycle cyc=%0d txd/busy/ovf=%b%b%b required %b%b%b",
                             cyc, TXD, BUSY, OVERFLOW, m_txd(), m_busy(), m_ovf);
                end
            end
        end
        checks++;
        if (rx_q.size() != 10) begin
            failures++;
            $display("FAIL wrap_frame_count got %0d required 10", rx_q.size());
        end
        for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== want[i]) begin
                failures++;
                $display("FAIL wrap_byte[%0d] got 0x%02h required 0x%02h", i, rx_q[i], want[i]);
            end
        end
    endtask

    task automatic test_random();
        clear_logs();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) OUT_DATA = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if (TXD !== m_txd() || BUSY !== m_busy() || OVERFLOW !== m_ovf) begin
                failures++;
                $display("FAIL random_cycle cyc=%0d txd/busy/ovf=%b%b%b required %b%b%b",
                         cyc, TXD, BUSY, OVERFLOW, m_txd(), m_busy(), m_ovf);
            end
        end
        for (int c = 0; c < (DEPTH + 2) * FRAME; c++) tick();
        checks++;
        if (rx_q.size() != exp_bytes.size()) begin
            failures++;
            $display("FAIL random_frame_count got %0d required %0d", rx_q.size(), exp_bytes.size());
        end
        for (int i = 0; i < rx_q.size() && i < exp_bytes.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_bytes[i]) begin
                failures++;
                $display("FAIL random_byte[%0d] got 0x%02h required 0x%02h", i, rx_q[i], exp_bytes[i]);
            end
        end
    endtask

`ifdef OUT_UART_PARITY_EN
    task automatic test_parity();
        logic [3:0] vals[2];
        logic       pars[2];
        logic [7:0] got;
        logic       gp;
        vals[0] = 4'h3; pars[0] = 1'b0;
        vals[1] = 4'h7; pars[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            apply_reset();
            OUT_DATA = vals[k];
            for (int c = 0; c < FRAME + 10; c++) begin
                tick();
                checks++;
                if (TXD !== m_txd() || BUSY !== m_busy() || OVERFLOW !== m_ovf) begin
                    failures++;
                    $display("FAIL parity_cycle cyc=%0d txd/busy/ovf=%b%b%b required %b%b%b",
                             cyc, TXD, BUSY, OVERFLOW, m_txd(), m_busy(), m_ovf);
                end
            end
            got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
            gp  = (rx_par_q.size() > 0) ? rx_par_q[0] : 1'bx;
            checks++;
            if (rx_q.size() != 1 || got !== ascii_hex(vals[k]) || gp !== pars[k]) begin
                failures++;
                $display("FAIL parity_frame[%0d] byte=0x%02h par=%b required 0x%02h par=%b",
                         k, got, gp, ascii_hex(vals[k]), pars[k]);
            end
        end
        checks++;
        if (FRAME != 11 * CPB || rx_start_q.size() != 1) begin
            failures++;
            $display("FAIL parity_frame_len frames=%0d required 1 of %0d cycles", rx_start_q.size(), 11 * CPB);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_back_to_back_overflow();
        test_clr_mid_frame();
        test_wrap();
        test_random();
`ifdef OUT_UART_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/out_uart_tx.md
# out_uart_tx

Serial output stage downstream of the TD4 core's 4-bit output port register. It watches the port value, queues every change in a small FIFO, and transmits each queued nibble as an ASCII hex character ('0'–'9', 'A'–'F') on an 8N1 UART line. This lets a host terminal log program output without tapping the LED pins.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per UART bit; legal range ≥2.
- FIFO_DEPTH, default 4: nibble queue depth; power of two, ≥2.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- CLR  in  1  asynchronous, active-low reset.
- OUT_DATA  in  4  value of the core's output port register.
- TXD  out  1  UART serial line; idles high.
- BUSY  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- OVERFLOW  out  1  sticky; set when a change is dropped because the FIFO is full. Cleared only by CLR.

## Operation
- Change detector:
  - prev register, reset value 4'h0, loaded from OUT_DATA every edge.
  - Push request = (OUT_DATA != prev). A constant value produces no push, and the core's reset value of 0 produces no spurious push.
- FIFO:
  - FIFO_DEPTH entries, 4 bits wide; read/write pointers plus a count.
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the nibble is dropped and OVERFLOW is set.
- Encoding at pop: nibble 0–9 → 8'h30+n; nibble A–F → 8'h37+n.
- FSM states: IDLE → START → DATA → STOP → IDLE/START.
  - IDLE: TXD=1. If the FIFO is non-empty: pop, load the shift register with the encoded byte, go to START.
  - START: TXD=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each; 3-bit bit index.
  - STOP: TXD=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets on every state entry.

## Timing
- Reset values: TXD=1, BUSY=0, OVERFLOW=0, FIFO empty, prev=0, state IDLE.
- Asserting CLR mid-frame forces TXD high immediately and discards the frame and FIFO contents.
- Latency, with OUT_DATA changing before edge k:
  - push at edge k;
  - pop and START entry at edge k+1;
  - TXD low from edge k+1.
- Frame length is 10×CLKS_PER_BIT cycles (11× with parity).
- Back-to-back frames: a stop bit is followed immediately by the next start bit.
- Pointer wrap-around is modulo FIFO_DEPTH.
- BUSY is registered-equivalent: it is derived from registered state and count, with no combinational path from OUT_DATA.

## Configuration
- OUT_UART_PARITY_EN defined:
  - a PARITY state is inserted between DATA and STOP;
  - it transmits even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles;
  - frame is 8E1, 11 bits.
- Undefined: no PARITY state; frame is 8N1, 10 bits.

## Test plan
- CLKS_PER_BIT=4, OUT_DATA 0→5: TXD falls 2 edges after the change, then sends 0x35 LSB first (1,0,1,0,1,1,0,0) and a stop bit. BUSY drops after 40 cycles. OVERFLOW=0.
- OUT_DATA 0→A: 0x41 transmitted. Holding A for 100 cycles produces no further frames.
- FIFO_DEPTH=4, OUT_DATA changes every cycle 1,2,3,4,5,6 from idle: frames 0x31–0x35 sent back-to-back with no idle gap; 6 is dropped; OVERFLOW=1 and stays 1 until CLR.
- CLR asserted mid-DATA: TXD=1 and BUSY=0 immediately. After release with OUT_DATA unchanged at its last value (non-zero vs. prev=0), exactly one frame for that value is sent.
- Pointer wrap: 10 spaced changes (one per frame time) → 10 correct frames; count never exceeds 1.
- With OUT_UART_PARITY_EN, OUT_DATA 0→3 (0x33, four ones): parity bit 0, frame 11 bit-times. 0→7 (0x37, five ones): parity bit 1.
